// File: rtl/ahb_slv_pkg.sv
// Shared constants, FSM state type and size mapping
// for the AHB-Lite slave front end.
package ahb_slv_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR2
  } state_e;

  // Oversized HSIZE codes map to the unused rf_size code 2'b11.
  function automatic logic [1:0] to_rf_size(input logic [2:0] hsize);
    return hsize[2] ? 2'b11 : hsize[1:0];
  endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Byte-lane shift/mask between AHB lanes and right-justified
// register file data; left_i selects the read direction.
module ahb_lane_steer
  import ahb_slv_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        left_i,
  output logic [31:0] data_o
);

  logic [4:0]  sh;
  logic [31:0] mask;

  // Shift amount uses the offset aligned down to the transfer size.
  always_comb begin
    sh   = '0;
    mask = '1;
    unique case (size_i)
      HSIZE_BYTE[1:0]: begin
        sh   = {off_i, 3'b000};
        mask = 32'h0000_00FF;
      end
      HSIZE_HALF[1:0]: begin
        sh   = {off_i[1], 4'b0000};
        mask = 32'h0000_FFFF;
      end
      default: ;
    endcase
    data_o = left_i ? (data_i << sh)
                    : ((data_i >> sh) & mask);
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end driving the register file port.
// Define AHB_SLV_ALIGN_CHECK_EN to reject unaligned half/word.
module ahb_slave_if
  import ahb_slv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          REG_DEPTH = 32,
  parameter int          RF_AW     = $clog2(REG_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic             rf_en,
  output logic             rf_we,
  output logic             rf_re,
  output logic [RF_AW-1:0] rf_addr,
  output logic [1:0]       rf_size,
  output logic [31:0]      rf_wdata,
  input  logic [31:0]      rf_rdata,
  input  logic             rf_done,
  input  logic             rf_check
);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic [1:0]       size_q, size_d;
  logic [RF_AW-1:0] addr_q, addr_d;

  logic        take;
  logic        local_err;
  logic        err_now;
  logic        ok_ph;
  logic [31:0] wr_lane;
  logic [31:0] rd_lane;
  logic        unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // A new address phase is taken only when this slave is ready too.
  assign take = HSEL & HREADY & HTRANS[1] & HREADYOUT;

  // Address-phase checks producing the captured local error flag.
  always_comb begin
    local_err = (HADDR[31:RF_AW] != BASE_ADDR[31:RF_AW])
              | (HSIZE >= 3'b011);
`ifdef AHB_SLV_ALIGN_CHECK_EN
    if (HSIZE == HSIZE_HALF && HADDR[0])
      local_err = 1'b1;
    if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)
      local_err = 1'b1;
`endif
  end

  // State and captured address-phase fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      write_q <= write_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
    end
  end

  // Next state and capture of a newly taken address phase.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    err_d   = err_q;
    size_d  = size_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE:
        if (take) state_d = ST_DATA;
      ST_DATA:
        if (err_now)      state_d = ST_ERR2;
        else if (rf_done) state_d = take ? ST_DATA : ST_IDLE;
      ST_ERR2:
        state_d = take ? ST_DATA : ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_DATA);
    if (take) begin
      write_d = HWRITE;
      size_d  = to_rf_size(HSIZE);
      addr_d  = HADDR[RF_AW-1:0];
      err_d   = local_err;
    end
  end

  ahb_lane_steer u_wr_steer (
    .data_i (HWDATA),
    .size_i (size_q),
    .off_i  (addr_q[1:0]),
    .left_i (1'b0),
    .data_o (wr_lane)
  );

  ahb_lane_steer u_rd_steer (
    .data_i (rf_rdata),
    .size_i (size_q),
    .off_i  (addr_q[1:0]),
    .left_i (1'b1),
    .data_o (rd_lane)
  );

  // Register file strobes and AHB response for the data phase.
  always_comb begin
    err_now  = (state_q == ST_DATA) & (err_q | rf_check);
    ok_ph    = valid_q & ~err_q & ~rst;
    rf_en    = ok_ph;
    rf_we    = ok_ph & write_q;
    rf_re    = ok_ph & ~write_q;
    rf_addr  = addr_q;
    rf_size  = size_q;
    rf_wdata = rf_we ? wr_lane : '0;
    HRDATA   = rf_re ? rd_lane : '0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      ST_DATA: begin
        HREADYOUT = ~err_now & rf_done;
        HRESP     = err_now;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Bench for ahb_slave_if: vector table, hand sequences and a
// randomized pipelined master against a byte-level memory model.
module tb_ahb_slave_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        rf_en;
  logic        rf_we;
  logic        rf_re;
  logic [4:0]  rf_addr;
  logic [1:0]  rf_size;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;
  logic        rf_done;
  logic        rf_check;

  always #5 clk = ~clk;

  ahb_slave_if #(
    .BASE_ADDR (32'h0000_0000),
    .REG_DEPTH (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .rf_en     (rf_en),
    .rf_we     (rf_we),
    .rf_re     (rf_re),
    .rf_addr   (rf_addr),
    .rf_size   (rf_size),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata),
    .rf_done   (rf_done),
    .rf_check  (rf_check)
  );

  // single-slave bus: the bus ready is this slave's ready
  assign HREADY = HREADYOUT;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- register file model ----------------
  logic [7:0] mem [32];

  function automatic int nbr(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] lmask(input int n);
    return (n >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
  endfunction

  always_comb begin
    rf_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (i < nbr(rf_size) && int'(rf_addr) + i < 32)
        rf_rdata[8*i +: 8] = mem[int'(rf_addr) + i];
    rf_check = rf_en &&
      ((int'(rf_addr) + nbr(rf_size) > 32) ||
       (rf_we && ((rf_wdata & ~lmask(nbr(rf_size))) != 0)));
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else if (rf_en && rf_we && rf_done && !rf_check) begin
      for (int i = 0; i < nbr(rf_size); i++)
        mem[int'(rf_addr) + i] <= rf_wdata[8*i +: 8];
    end
  end

  // ---------------- bus helpers ----------------
  task automatic drv_ap(input logic [31:0] a, input logic [2:0] s,
                        input logic w);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HSIZE = s; HWRITE = w;
  endtask

  task automatic drv_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HSIZE = '0; HWRITE = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic        en;
    logic [31:0] expd;
  } vec_t;

`ifdef AHB_SLV_ALIGN_CHECK_EN
  localparam logic EN_1D = 1'b0;
`else
  localparam logic EN_1D = 1'b1;
`endif

  task automatic apply_vec(input vec_t v, input string nm);
    @(negedge clk);
    drv_ap(v.addr, v.size, v.wr);
    rf_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_idle();
    HWDATA = v.wdata;
    #2;
    if (v.err) begin
      chk({nm, " err1 rdy"}, HREADYOUT, 1'b0);
      chk({nm, " err1 resp"}, HRESP, 1'b1);
      chk({nm, " err1 en"}, rf_en, v.en);
      @(posedge clk);
      @(negedge clk);
      #2;
      chk({nm, " err2 rdy"}, HREADYOUT, 1'b1);
      chk({nm, " err2 resp"}, HRESP, 1'b1);
    end else begin
      chk({nm, " rdy"}, HREADYOUT, 1'b1);
      chk({nm, " resp"}, HRESP, 1'b0);
      if (v.wr) chk({nm, " wdata"}, rf_wdata, v.expd);
      else      chk({nm, " rdata"}, HRDATA, v.expd);
    end
    @(posedge clk);
  endtask

  // ---------------- transaction-level reference ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } tx_t;

  tx_t        txq[$];
  logic [7:0] refmem [32];

  function automatic int nbt(input logic [2:0] s);
    return (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
  endfunction

  function automatic int lane(input tx_t t);
    if (t.size == 3'd0) return int'(t.addr % 4);
    if (t.size == 3'd1) return int'(t.addr % 4) & 2;
    return 0;
  endfunction

  function automatic bit pred_err(input tx_t t);
    bit e;
    e = (t.addr > 31) || (t.size > 2);
    if (!e && int'(t.addr) + nbt(t.size) > 32) e = 1;
`ifdef AHB_SLV_ALIGN_CHECK_EN
    if (!e && t.size == 3'd1 && (t.addr % 2) != 0) e = 1;
    if (!e && t.size == 3'd2 && (t.addr % 4) != 0) e = 1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] expw(input tx_t t);
    logic [31:0] r = '0;
    int l = lane(t);
    for (int i = 0; i < nbt(t.size); i++)
      r[8*i +: 8] = t.wdata[8*(l+i) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] expr(input tx_t t);
    logic [31:0] r = '0;
    int l = lane(t);
    for (int i = 0; i < nbt(t.size); i++)
      r[8*(l+i) +: 8] = refmem[int'(t.addr) + i];
    return r;
  endfunction

  task automatic commit(input tx_t t);
    int l = lane(t);
    for (int i = 0; i < nbt(t.size); i++)
      refmem[int'(t.addr) + i] = t.wdata[8*(l+i) +: 8];
  endtask

  task automatic run_q(input int gap, input bit stalls);
    tx_t dp, ap;
    bit  dpv = 0, e2 = 0, apv = 0, held = 0, rdy = 0, de;
    int  cyc = 0;
    while ((txq.size() != 0 || dpv || e2) && cyc < 4000) begin
      @(negedge clk);
      apv = txq.size() != 0 &&
            (held || $urandom_range(0, 99) >= gap);
      if (apv) begin
        ap = txq[0];
        HSEL = 1'b1; HTRANS = {1'b1, 1'($urandom)};
        HADDR = ap.addr; HSIZE = ap.size; HWRITE = ap.wr;
      end else begin
        HSEL = 1'($urandom);
        HTRANS = {~HSEL, 1'($urandom)};
        HADDR = $urandom; HSIZE = 3'($urandom);
        HWRITE = 1'($urandom);
      end
      HWDATA = (dpv && dp.wr) ? dp.wdata : $urandom;
      rf_done = !stalls || ($urandom_range(0, 3) != 0);
      #2;
      de = dpv && pred_err(dp);
      if (e2) begin
        chk("rnd e2 rdy", HREADYOUT, 1'b1);
        chk("rnd e2 resp", HRESP, 1'b1);
        chk("rnd e2 en", rf_en, 1'b0);
        rdy = 1;
      end else if (de) begin
        chk("rnd e1 rdy", HREADYOUT, 1'b0);
        chk("rnd e1 resp", HRESP, 1'b1);
        rdy = 0;
      end else if (dpv) begin
        chk("rnd rdy", HREADYOUT, rf_done);
        chk("rnd resp", HRESP, 1'b0);
        chk("rnd en", rf_en, 1'b1);
        chk("rnd we", rf_we, dp.wr);
        chk("rnd addr", rf_addr, dp.addr[4:0]);
        chk("rnd size", rf_size, dp.size[1:0]);
        if (dp.wr)        chk("rnd wdata", rf_wdata, expw(dp));
        else if (rf_done) chk("rnd rdata", HRDATA, expr(dp));
        rdy = rf_done;
      end else begin
        chk("rnd idle rdy", HREADYOUT, 1'b1);
        chk("rnd idle resp", HRESP, 1'b0);
        chk("rnd idle en", rf_en, 1'b0);
        chk("rnd idle rdata", HRDATA, 32'h0);
        rdy = 1;
      end
      @(posedge clk);
      held = apv && !rdy;
      if (e2) e2 = 0;
      else if (de) begin e2 = 1; dpv = 0; end
      else if (dpv && rdy) begin
        if (dp.wr) commit(dp);
        dpv = 0;
      end
      if (apv && rdy) begin
        dp = ap; dpv = 1;
        void'(txq.pop_front());
      end
      cyc++;
    end
    if (cyc >= 4000) begin
      n_cmp++; n_bad++;
      $display("FAIL run_q timeout: got %0d cycles want < 4000", cyc);
    end
    @(negedge clk);
    drv_idle();
  endtask

  // ---------------- main ----------------
  vec_t vt [14];
  tx_t  t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 32'h04, 3'd2, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 32'h04, 3'd2, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'h0A, 3'd0, 32'h00AB0000, 1'b0, 1'b1, 32'h000000AB};
    vt[3]  = '{1'b0, 32'h0A, 3'd0, 32'h0,        1'b0, 1'b1, 32'h00AB0000};
    vt[4]  = '{1'b1, 32'h1D, 3'd2, 32'hDEADBEEF, 1'b1, EN_1D, 32'h0};
    vt[5]  = '{1'b0, 32'h1C, 3'd2, 32'h0,        1'b0, 1'b1, 32'h0};
    vt[6]  = '{1'b1, 32'h00, 3'd3, 32'h11111111, 1'b1, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 32'h40, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0};
    vt[8]  = '{1'b1, 32'h12, 3'd1, 32'hCAFE1234, 1'b0, 1'b1, 32'h0000CAFE};
    vt[9]  = '{1'b0, 32'h12, 3'd1, 32'h0,        1'b0, 1'b1, 32'hCAFE0000};
    vt[10] = '{1'b0, 32'h10, 3'd2, 32'h0,        1'b0, 1'b1, 32'hCAFE0000};
    vt[11] = '{1'b1, 32'h07, 3'd0, 32'h5A000000, 1'b0, 1'b1, 32'h0000005A};
    vt[12] = '{1'b0, 32'h04, 3'd2, 32'h0,        1'b0, 1'b1, 32'h5AADBEEF};
    vt[13] = '{1'b0, 32'h08, 3'd2, 32'h0,        1'b0, 1'b1, 32'h00AB0000};

    rst = 1'b1;
    drv_idle();
    HWDATA = 32'hA5A5_5A5A;
    rf_done = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst rdy", HREADYOUT, 1'b1);
    chk("rst resp", HRESP, 1'b0);
    chk("rst rdata", HRDATA, 32'h0);
    chk("rst en", rf_en, 1'b0);
    chk("rst we", rf_we, 1'b0);
    chk("rst re", rf_re, 1'b0);
    chk("rst addr", rf_addr, 5'h0);
    chk("rst size", rf_size, 2'h0);
    chk("rst wdata", rf_wdata, 32'h0);
    rst = 1'b0;

    for (int k = 0; k < 14; k++)
      apply_vec(vt[k], $sformatf("vec%0d", k));

    // back-to-back write then read of the same word
    @(negedge clk);
    drv_ap(32'h00, 3'd2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drv_ap(32'h00, 3'd2, 1'b0);
    HWDATA = 32'h1234_5678;
    #2;
    chk("b2b wr rdy", HREADYOUT, 1'b1);
    chk("b2b wr wdata", rf_wdata, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    drv_idle();
    HWDATA = 32'h0;
    #2;
    chk("b2b rd rdy", HREADYOUT, 1'b1);
    chk("b2b rd resp", HRESP, 1'b0);
    chk("b2b rd rdata", HRDATA, 32'h1234_5678);
    @(posedge clk);

    // reset during the second error cycle, with a new phase pending
    @(negedge clk);
    drv_ap(32'h1D, 3'd2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drv_idle();
    HWDATA = 32'hFFFF_FFFF;
    #2;
    chk("rerr e1 rdy", HREADYOUT, 1'b0);
    chk("rerr e1 resp", HRESP, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drv_ap(32'h00, 3'd2, 1'b0);
    rst = 1'b1;
    #2;
    chk("rerr e2 rdy", HREADYOUT, 1'b1);
    chk("rerr e2 resp", HRESP, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drv_idle();
    #2;
    chk("rerr post rdy", HREADYOUT, 1'b1);
    chk("rerr post resp", HRESP, 1'b0);
    chk("rerr post en", rf_en, 1'b0);
    chk("rerr post rdata", HRDATA, 32'h0);
    @(posedge clk);
    apply_vec('{1'b1, 32'h01, 3'd0, 32'h0000_7700, 1'b0, 1'b1,
                32'h0000_0077}, "post wr");
    apply_vec('{1'b0, 32'h01, 3'd0, 32'h0, 1'b0, 1'b1,
                32'h0000_7700}, "post rd");
    apply_vec('{1'b0, 32'h00, 3'd2, 32'h0, 1'b0, 1'b1,
                32'h0000_7700}, "post rdw");

    // randomized pipelined traffic against the byte model
    for (int a = 0; a < 8; a++) begin
      t.wr = 1'b1; t.addr = 32'(4 * a); t.size = 3'd2;
      t.wdata = $urandom;
      txq.push_back(t);
    end
    run_q(0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 19);
      t.wr = 1'($urandom);
      t.addr = (r == 0) ? 32'h40 :
               (r == 1) ? 32'($urandom) :
                          32'($urandom_range(0, 31));
      t.size = ($urandom_range(0, 9) > 7) ?
               3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      t.wdata = $urandom;
      txq.push_back(t);
    end
    run_q(30, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
# ahb_slave_if

AHB-Lite slave front end for the register file, sitting directly upstream of it. The block samples pipelined AHB address phases and registers them. In the following data phase it drives the register file's simple select/write/read/address/size/data interface. It also handles byte-lane steering and returns HRDATA, HREADYOUT and HRESP, including the two-cycle ERROR response.

## Interface
- BASE_ADDR, 32'h0000_0000: slave base; bits above RF_AW must match.
- REG_DEPTH, 32: register file depth in bytes.
- RF_AW, $clog2(REG_DEPTH): register file address width, derived.
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  address-phase address
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  000 byte, 001 half, 010 word
- HWDATA  in  32  data-phase write data
- HREADY  in  1  bus-wide ready
- HRDATA  out  32  read data, lane-steered
- HREADYOUT  out  1  slave ready
- HRESP  out  1  1 = ERROR
- rf_en  out  1  register file select
- rf_we  out  1  register file write enable
- rf_re  out  1  register file read enable
- rf_addr  out  RF_AW  byte address
- rf_size  out  2  00 byte, 01 half, 10 word
- rf_wdata  out  32  write data, right-justified
- rf_rdata  in  32  register file read data
- rf_done  in  1  register file ready
- rf_check  in  1  register file error

## Operation
- Address phase is accepted when `HSEL & HREADY & HTRANS[1]`.
  - On acceptance, the block registers: valid, write, size, address low bits, and a local error flag.
  - Local error is raised when: HADDR[31:RF_AW] != BASE_ADDR[31:RF_AW], or HSIZE >= 3'b011.
- Data phase is the cycle after acceptance, while valid = 1.
  - Without local error: rf_en = 1, rf_we = write, rf_re = !write, rf_addr = captured address, rf_size = HSIZE[1:0].
  - With local error: rf_en = rf_we = rf_re = 0.
- Write lane steering:
  - Byte: rf_wdata = (HWDATA >> 8·addr[1:0]) & 32'hFF.
  - Half: rf_wdata = (HWDATA >> 16·addr[1]) & 32'hFFFF.
  - Word: rf_wdata = HWDATA.
  - Upper bits are always zeroed, so the register file's data check never fires.
- Read lane steering: HRDATA = rf_rdata shifted left by the same amount. HRDATA = 0 outside read data phases.
- FSM states: IDLE, DATA, ERR2.
  - IDLE → DATA on acceptance.
  - DATA → DATA (back-to-back) when a new acceptance occurs and the current phase completes without error.
  - DATA → IDLE when the phase completes with no new acceptance.
  - DATA → ERR2 when the phase has an error, i.e. local error or rf_check.
  - ERR2 → DATA on acceptance, else IDLE.
- Outputs by state:
  - DATA without error: HREADYOUT = rf_done, HRESP = 0. While rf_done = 0, hold all captured fields.
  - DATA with error: HREADYOUT = 0, HRESP = 1 (first ERROR cycle).
  - ERR2: HREADYOUT = 1, HRESP = 1 (second ERROR cycle). New address phases may be accepted; the master may also drive IDLE.
- IDLE/BUSY transfers, and transfers with HSEL = 0, produce no data phase. Outputs stay at HREADYOUT = 1, HRESP = 0.

## Timing
- Reset (synchronous `rst` high):
  - state = IDLE, valid = 0.
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0.
  - rf_en = rf_we = rf_re = 0, rf_addr = 0, rf_size = 0, rf_wdata = 0.
- Reset during DATA or ERR2 aborts the transfer. The next cycle shows reset values, and no register file write occurs in that cycle.
- Latency:
  - Zero-wait OKAY transfers complete in the data-phase cycle itself.
  - ERROR costs exactly 2 cycles.
- Register file writes commit at the clock edge ending the data phase. A read of the same address in the following data phase returns the new value.
- rf_done, rf_rdata and rf_check are used combinationally within the data phase.

## Configuration
- `AHB_SLV_ALIGN_CHECK_EN`, when defined: half transfers with addr[0] = 1 and word transfers with addr[1:0] != 0 set the local error flag. They receive an ERROR response with no register file access.
- When undefined: unaligned transfers are forwarded to the register file. Lane steering uses the address aligned down to the transfer size.

## Structure
- Package `ahb_slv_pkg` holds:
  - htrans/hsize localparams
  - the FSM state enum
  - the HSIZE → rf_size mapping function
- Sub-module `ahb_lane_steer` is a combinational shift/mask, instantiated once for the write path and once for the read path.

## Test plan
- Word write of 32'hDEADBEEF at 0x04, then word read at 0x04: HRDATA = 32'hDEADBEEF with no wait states, HRESP = 0 throughout.
- Byte write at 0x0A with HWDATA = 32'h00AB_0000: rf_wdata = 32'h0000_00AB. A byte read at 0x0A then returns HRDATA = 32'h00AB_0000.
- Word write at 0x1D (rf_check = 1): two-cycle ERROR (HREADYOUT 0 then 1, HRESP 1 for both cycles). Register file contents are unchanged.
- HSIZE = 3'b011, and separately HADDR = 0x40: ERROR response in both cases, with rf_en never asserted.
- Back-to-back pipeline: write 32'h1234_5678 to 0x00 with a read of 0x00 in the next address phase. The read returns 32'h1234_5678 with no stall.
- `rst` asserted during the ERR2 cycle: on the next cycle HREADYOUT = 1, HRESP = 0 and state = IDLE. A subsequent transfer completes OKAY.
